// File: rtl/block_data_memory_pkg.sv
// Purpose: shared defaults and FSM state encoding for the block data memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package block_data_memory_pkg;

  localparam int LATENCY_DEF      = 5;
  localparam int BLOCK_ADDR_W_DEF = 6;
  localparam int BLOCK_W_DEF      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/block_data_memory_if.sv
// Purpose: cache <-> block memory request/response bundle.
// Latency: n/a (wires only).
// Backpressure: BUSYWAIT from the memory stalls the cache.
interface block_data_memory_if #(
  parameter int BLOCK_ADDR_W = block_data_memory_pkg::BLOCK_ADDR_W_DEF,
  parameter int BLOCK_W      = block_data_memory_pkg::BLOCK_W_DEF
);
  logic                    READ;
  logic                    WRITE;
  logic [BLOCK_ADDR_W-1:0] ADDRESS;
  logic [BLOCK_W-1:0]      WRITEDATA;
  logic [BLOCK_W-1:0]      READDATA;
  logic                    BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );
endinterface

// File: rtl/block_data_memory_mem_array.sv
// Purpose: single-port word array, combinational read, synchronous write and clear.
// Latency: write lands at the clock edge; read data follows addr_i combinationally.
// Backpressure: none; the caller sequences accesses.
module mem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear wins over write so a reset discards any coincident store.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/block_data_memory.sv
// Purpose: block-granular data memory behind the data cache, fixed-latency FSM.
// Latency: LATENCY+1 edges from request to DONE; READDATA valid in DONE.
// Backpressure: BUSYWAIT high while a request is pending in IDLE or in ACCESS.
module block_data_memory
  import block_data_memory_pkg::*;
#(
  parameter int LATENCY      = LATENCY_DEF,
  parameter int BLOCK_ADDR_W = BLOCK_ADDR_W_DEF,
  parameter int BLOCK_W      = BLOCK_W_DEF
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  block_data_memory_if.slave   cache_if
);
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic [BLOCK_W-1:0]      wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic [BLOCK_W-1:0]      rdata_q, rdata_d;
  logic                    mem_we;
  logic [BLOCK_W-1:0]      mem_rdata;

  // Next-state, counter, capture and array-strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cache_if.READ || cache_if.WRITE) begin
          addr_d  = cache_if.ADDRESS;
          wdata_d = cache_if.WRITEDATA;
          wr_d    = cache_if.WRITE;      // read+write together resolves to write
          cnt_d   = 4'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (wr_q) mem_we  = 1'b1;
          else      rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset forces the idle, zeroed state.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  mem_array #(
    .ADDR_W (BLOCK_ADDR_W),
    .DATA_W (BLOCK_W)
  ) u_mem_array (
    .clk_i   (CLOCK),
    .clr_i   (RESET),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign cache_if.READDATA = rdata_q;
  assign cache_if.BUSYWAIT = ((state_q == IDLE) && (cache_if.READ || cache_if.WRITE))
                             || (state_q == ACCESS);
endmodule

// File: tb/tb_block_data_memory.sv
module tb_block_data_memory;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   edges;
  logic [31:0] rd;

  always #5 CLOCK = ~CLOCK;

  block_data_memory_if #(.BLOCK_ADDR_W(6), .BLOCK_W(32)) bus1 ();
  block_data_memory_if #(.BLOCK_ADDR_W(6), .BLOCK_W(32)) bus2 ();

  block_data_memory #(.LATENCY(5), .BLOCK_ADDR_W(6), .BLOCK_W(32)) dut1 (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .cache_if (bus1)
  );

  block_data_memory #(.LATENCY(1), .BLOCK_ADDR_W(6), .BLOCK_W(32)) dut2 (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .cache_if (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [5:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus1.READ = r; bus1.WRITE = w; bus1.ADDRESS = a; bus1.WRITEDATA = d;
    end else begin
      bus2.READ = r; bus2.WRITE = w; bus2.ADDRESS = a; bus2.WRITEDATA = d;
    end
  endtask

  function automatic logic busy(input int sel);
    return (sel == 0) ? bus1.BUSYWAIT : bus2.BUSYWAIT;
  endfunction

  // Counts rising edges while BUSYWAIT is high; ends at the negedge of DONE.
  task automatic wait_done(input int sel, output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLOCK);
      if (!busy(sel)) done = 1;
      else begin
        @(posedge CLOCK); #1;
        n++;
      end
    end
    if (!done) chk("busywait_timeout", 32'd1, 32'd0);
  endtask

  task automatic req(input int sel, input logic r, input logic w, input logic [5:0] a,
                     input logic [31:0] d, output int n, output logic [31:0] rdata);
    @(posedge CLOCK); #1;
    drive(sel, r, w, a, d);
    wait_done(sel, n);
    drive(sel, 1'b0, 1'b0, a, d);
    rdata = (sel == 0) ? bus1.READDATA : bus2.READDATA;
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 6'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 6'h00, 32'h0);
    RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    @(negedge CLOCK);
    chk("reset_readdata", bus1.READDATA, 32'h0);
    chk("reset_busy",     32'(bus1.BUSYWAIT), 32'd0);
    chk("reset_state",    32'(dut1.state_q), 32'd0);
    drive(0, 1'b1, 1'b0, 6'h15, 32'h0);
    #1 chk("idle_busy_comb", 32'(bus1.BUSYWAIT), 32'd1);
    drive(0, 1'b0, 1'b0, 6'h15, 32'h0);

    // read after reset
    req(0, 1'b1, 1'b0, 6'h15, 32'h0, edges, rd);
    chk("rd15_edges", 32'(edges), 32'd6);
    chk("rd15_data",  rd, 32'h0);

    // write then read back
    req(0, 1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, edges, rd);
    chk("wr2a_edges", 32'(edges), 32'd6);
    chk("wr2a_rdata_kept", rd, 32'h0);
    req(0, 1'b1, 1'b0, 6'h2A, 32'h0, edges, rd);
    chk("rd2a_data", rd, 32'hDEADBEEF);
    req(0, 1'b1, 1'b0, 6'h2B, 32'h0, edges, rd);
    chk("rd2b_data", rd, 32'h0);

    // inputs change and request drops during ACCESS cycle 2
    @(posedge CLOCK); #1;
    drive(0, 1'b0, 1'b1, 6'h05, 32'h11223344);
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    drive(0, 1'b0, 1'b0, 6'h06, 32'hFFFFFFFF);
    wait_done(0, edges);
    chk("midacc_edges", 32'(edges), 32'd4);
    req(0, 1'b1, 1'b0, 6'h05, 32'h0, edges, rd);
    chk("rd05_data", rd, 32'h11223344);
    req(0, 1'b1, 1'b0, 6'h06, 32'h0, edges, rd);
    chk("rd06_data", rd, 32'h0);

    // READ and WRITE together act as a write
    req(0, 1'b1, 1'b0, 6'h2A, 32'h0, edges, rd);
    req(0, 1'b1, 1'b1, 6'h3F, 32'hA5A5A5A5, edges, rd);
    chk("rdwr_rdata_kept", rd, 32'hDEADBEEF);
    req(0, 1'b1, 1'b0, 6'h3F, 32'h0, edges, rd);
    chk("rd3f_data", rd, 32'hA5A5A5A5);

    // reset in ACCESS cycle 3 of a write
    @(posedge CLOCK); #1;
    drive(0, 1'b0, 1'b1, 6'h10, 32'h12345678);
    repeat (3) begin @(posedge CLOCK); #1; end
    RESET = 1'b1;
    drive(0, 1'b0, 1'b0, 6'h10, 32'h0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("rst_mid_state", 32'(dut1.state_q), 32'd0);
    chk("rst_mid_busy",  32'(bus1.BUSYWAIT), 32'd0);
    chk("rst_mid_rdata", bus1.READDATA, 32'h0);
    req(0, 1'b1, 1'b0, 6'h10, 32'h0, edges, rd);
    chk("rd10_after_rst", rd, 32'h0);
    req(0, 1'b1, 1'b0, 6'h3F, 32'h0, edges, rd);
    chk("rd3f_cleared", rd, 32'h0);

    // request held through DONE is not recaptured there
    @(posedge CLOCK); #1;
    drive(0, 1'b1, 1'b0, 6'h2A, 32'h0);
    wait_done(0, edges);
    chk("hold_edges", 32'(edges), 32'd6);
    chk("hold_done_busy", 32'(bus1.BUSYWAIT), 32'd0);
    @(posedge CLOCK); #1;
    chk("hold_idle_state", 32'(dut1.state_q), 32'd0);
    chk("hold_idle_busy",  32'(bus1.BUSYWAIT), 32'd1);
    wait_done(0, edges);
    drive(0, 1'b0, 1'b0, 6'h2A, 32'h0);
    chk("hold_second_edges", 32'(edges), 32'd6);

    // LATENCY=1 instance
    req(1, 1'b0, 1'b1, 6'h07, 32'hCAFEF00D, edges, rd);
    chk("lat1_wr_edges", 32'(edges), 32'd2);
    req(1, 1'b1, 1'b0, 6'h07, 32'h0, edges, rd);
    chk("lat1_rd_edges", 32'(edges), 32'd2);
    chk("lat1_rd_data",  rd, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/block_data_memory.md
BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 Parameter LATENCY, default 5, SHALL set the number of ACCESS-state cycles per request (legal range 1..15).
REQ-002 Parameter BLOCK_ADDR_W, default 6, SHALL set the block address width (64 blocks).
REQ-003 Parameter BLOCK_W, default 32, SHALL set the block width (four bytes).
REQ-004 Port CLOCK  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-005 Port RESET  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 Port READ  input  1  SHALL be the block read request from the data cache.
REQ-007 Port WRITE  input  1  SHALL be the block write-back request from the data cache.
REQ-008 Port ADDRESS  input  BLOCK_ADDR_W  SHALL be the block address ({tag,index}).
REQ-009 Port WRITEDATA  input  BLOCK_W  SHALL be the block to store.
REQ-010 Port READDATA  output  BLOCK_W  SHALL be the registered block read result.
REQ-011 Port BUSYWAIT  output  1  SHALL be the stall signal to the data cache.

Function
REQ-012 Storage SHALL be 2^BLOCK_ADDR_W words of BLOCK_W bits.
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-014 In IDLE with READ or WRITE high at a clock edge, the block SHALL capture ADDRESS, WRITEDATA and operation, load counter=LATENCY-1, and enter ACCESS.
REQ-015 If READ and WRITE are both high at capture, the block SHALL treat the request as a write.
REQ-016 In ACCESS, the counter SHALL decrement each edge; at the edge where counter==0 the block SHALL perform the array operation on the captured values and enter DONE.
REQ-017 The counter SHALL be 4 bits, SHALL never wrap, and SHALL hold 0 outside ACCESS.
REQ-018 A read SHALL load READDATA with the array word at that same edge.
REQ-019 A write SHALL update the whole word and SHALL leave READDATA unchanged.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; requests seen while in DONE SHALL NOT be captured.
REQ-021 BUSYWAIT SHALL be combinational: 1 when (IDLE and (READ or WRITE)) or ACCESS, otherwise 0.
REQ-022 Consequently, BUSYWAIT SHALL stay high from request assertion through LATENCY+1 rising edges and fall in DONE.
REQ-023 Changes to ADDRESS, WRITEDATA, READ or WRITE during ACCESS SHALL be ignored.
REQ-024 A request dropped mid-ACCESS SHALL still complete.
REQ-025 READDATA SHALL hold its last read value until the next read completes.
REQ-026 Back-to-back requests SHALL be spaced by at least one DONE cycle; the cache FSM satisfies this because it leaves MEM_READ/MEM_WRITE on the edge after BUSYWAIT falls.

Reset
REQ-027 RESET at a rising edge SHALL force state=IDLE, counter=0, READDATA=0 and all array words=0.
REQ-028 RESET SHALL take priority over every other event, including the completing ACCESS edge.
REQ-029 An in-flight write interrupted by RESET SHALL be discarded.
REQ-030 After reset, BUSYWAIT SHALL equal READ|WRITE (IDLE rule).

Structure
REQ-031 A shared package SHALL hold the LATENCY, BLOCK_ADDR_W and BLOCK_W defaults and the state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
REQ-032 The storage SHALL be one sub-module, mem_array: a synchronous single-port word array with write enable and synchronous clear.
REQ-033 The FSM, counter, capture registers and READDATA register SHALL reside in block_data_memory.

Verification
REQ-034 Reset then read: READ at addr 0x15 -> BUSYWAIT high for 6 edges, READDATA=0x00000000 in DONE.
REQ-035 Write then read: write 0xDEADBEEF to 0x2A, then read 0x2A -> READDATA=0xDEADBEEF.
REQ-036 Read-after-write: read 0x2B (not written) -> READDATA=0.
REQ-037 Mid-access changes: write 0x11223344 to 0x05, change ADDRESS to 0x06 and WRITEDATA to 0xFFFFFFFF at ACCESS cycle 2 -> 0x05=0x11223344 and 0x06=0.
REQ-038 Simultaneous requests: READ=WRITE=1, addr 0x3F, data 0xA5A5A5A5 -> treated as a write; READDATA unchanged.
REQ-039 Reset mid-write: RESET in ACCESS cycle 3 of a write of 0x12345678 to 0x10 -> state IDLE, 0x10 reads 0.
REQ-040 Request held through DONE: request held high in DONE -> no recapture; new BUSYWAIT rises only in the following IDLE cycle.
REQ-041 LATENCY=1 variant: BUSYWAIT high for exactly 2 edges.
